mdreg_shifter: RTL and testbench

- Parametrised working register for the iterative multiply/divide unit.
- Replaces the fixed-width, load-only product register with:
  - a configurable-width register;
  - a "step" mode that writes the adder result into the upper field and arithmetic-shifts right in the same edge;
  - an iteration counter with busy/done status.
- Sits between the multdiv control FSM and the add/sub datapath.

---
 rtl/mdreg_pkg.sv | 15 +
 rtl/mdreg_iter_ctr.sv | 50 +++++
 rtl/mdreg_shifter.sv | 53 +++++
 tb/tb_mdreg_shifter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mdreg_pkg.sv
// mdreg_pkg: shared constants and helpers for the multiply/divide working register.
package mdreg_pkg;
    localparam int R4_WIDTH   = 65;
    localparam int R4_UPPER_W = 32;
    localparam int R4_SHIFT   = 2;
    localparam int R4_ITER    = 16;
    localparam int R2_WIDTH   = 65;
    localparam int R2_UPPER_W = 32;
    localparam int R2_SHIFT   = 1;
    localparam int R2_ITER    = 32;

    function automatic int ctr_w(input int iter);
        return $clog2(iter + 1);
    endfunction
endpackage

// File: rtl/mdreg_iter_ctr.sv
// mdreg_iter_ctr: iteration counter with busy status and a one-cycle done pulse on the final step.
module mdreg_iter_ctr
    import mdreg_pkg::*;
#(
    parameter int ITER = R4_ITER,
    localparam int CW = ctr_w(ITER)
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic          step_i,
    output logic [CW-1:0] count_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          accept_o
);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          accept, term;

    // start and clear win over a step arriving in the same cycle
    assign accept = busy_q & step_i & ~start_i & ~clear_i;
    assign term   = accept & (count_q == LAST);

    always_comb begin
        count_d = (clear_i | start_i) ? '0 : accept ? count_q + CW'(1) : count_q;
        busy_d  = clear_i ? 1'b0 : start_i ? 1'b1 : term ? 1'b0 : busy_q;
        done_d  = term;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count_o  = count_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign accept_o = accept;
endmodule

// File: rtl/mdreg_shifter.sv
// mdreg_shifter: multiply/divide working register; a step merges the adder result into the
// upper field and arithmetic-shifts the whole register right in the same edge.
module mdreg_shifter
    import mdreg_pkg::*;
#(
    parameter int WIDTH   = R4_WIDTH,
    parameter int UPPER_W = R4_UPPER_W,
    parameter int SHIFT   = R4_SHIFT,
    parameter int ITER    = R4_ITER
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    input  logic                    ctrl_clear,
    input  logic                    ctrl_load,
    input  logic [WIDTH-1:0]        data_load,
    input  logic                    ctrl_step,
    input  logic [UPPER_W-1:0]      data_upper,
    output logic [WIDTH-1:0]        reg_out,
    output logic [ctr_w(ITER)-1:0]  iter_count,
    output logic                    busy,
    output logic                    done
);
    logic [WIDTH-1:0]        reg_q, reg_d, shifted;
    logic signed [WIDTH-1:0] merged;
    logic                    accept;

    mdreg_iter_ctr #(.ITER(ITER)) u_ctr (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .clear_i      (ctrl_clear),
        .start_i      (ctrl_load),
        .step_i       (ctrl_step),
        .count_o      (iter_count),
        .busy_o       (busy),
        .done_o       (done),
        .accept_o     (accept)
    );

    // shift kept in its own signed assignment so the ternary below cannot turn it logical
    assign merged  = {data_upper, reg_q[WIDTH-UPPER_W-1:0]};
    assign shifted = merged >>> SHIFT;

    always_comb begin
        reg_d = ctrl_clear ? '0 : ctrl_load ? data_load : accept ? shifted : reg_q;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) reg_q <= '0;
        else reg_q <= reg_d;
    end

    assign reg_out = reg_q;
endmodule

// File: tb/tb_mdreg_shifter.sv
// tb_mdreg_shifter: radix-4 and radix-2 instances driven in lockstep against a behavioural model.
module tb_mdreg_shifter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n, clr, ld, st;
    logic [64:0] dl;
    logic [31:0] du;
    logic [64:0] ra, rb;
    logic [4:0]  ca;
    logic [5:0]  cb;
    logic        ba, da, bb, db;

    mdreg_shifter #(.WIDTH(65), .UPPER_W(32), .SHIFT(2), .ITER(16)) dut_a (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_clear(clr), .ctrl_load(ld),
        .data_load(dl), .ctrl_step(st), .data_upper(du),
        .reg_out(ra), .iter_count(ca), .busy(ba), .done(da));

    mdreg_shifter #(.WIDTH(65), .UPPER_W(32), .SHIFT(1), .ITER(32)) dut_b (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_clear(clr), .ctrl_load(ld),
        .data_load(dl), .ctrl_step(st), .data_upper(du),
        .reg_out(rb), .iter_count(cb), .busy(bb), .done(db));

    int n_vec = 0, n_bad = 0;
    logic [64:0] m_reg[2];
    int          m_cnt[2];
    bit          m_busy[2], m_done[2];
    int          sh[2] = '{2, 1};
    int          it[2] = '{16, 32};

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_reg[k] = '0; m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [64:0] t;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_reg[k] = '0; m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
            end else if (ld) begin
                m_reg[k] = dl; m_cnt[k] = 0; m_busy[k] = 1; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_busy[k] && st) begin
                    t = {du, m_reg[k][32:0]};
                    repeat (sh[k]) t = {t[64], t[64:1]};
                    m_reg[k] = t;
                    m_cnt[k]++;
                    if (m_cnt[k] == it[k]) begin
                        m_busy[k] = 0; m_done[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        check("a_reg", ra, m_reg[0]);
        check("a_cnt", 65'(ca), 65'(m_cnt[0]));
        check("a_busy", 65'(ba), 65'(m_busy[0]));
        check("a_done", 65'(da), 65'(m_done[0]));
        check("b_reg", rb, m_reg[1]);
        check("b_cnt", 65'(cb), 65'(m_cnt[1]));
        check("b_busy", 65'(bb), 65'(m_busy[1]));
        check("b_done", 65'(db), 65'(m_done[1]));
    endtask

    task automatic cyc(input bit c, input bit l, input bit s, input logic [64:0] d, input logic [31:0] u);
        clr = c; ld = l; st = s; dl = d; du = u;
        @(posedge clock);
        model_edge();
        #1 compare();
    endtask

    function automatic logic [64:0] rand65();
        return 65'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        rst_n = 1'b0; clr = 0; ld = 0; st = 0; dl = '0; du = '0;
        mreset();
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        compare();

        cyc(0, 1, 0, '0, '0);
        cyc(0, 0, 1, '0, 32'hFFFF_FFFF);
        check("tp_step_reg", ra, 65'h1_FFFF_FFFF_8000_0000);
        check("tp_step_cnt", 65'(ca), 65'd1);

        cyc(0, 1, 0, 65'h10, '0);
        repeat (15) cyc(0, 0, 1, '0, '0);
        check("pre_done", 65'(da), 65'd0);
        cyc(0, 0, 1, '0, '0);
        check("done_hi", 65'(da), 65'd1);
        check("done_busy", 65'(ba), 65'd0);
        check("done_cnt", 65'(ca), 65'd16);
        check("done_reg", ra, 65'd0);
        cyc(0, 0, 1, '0, 32'h1234_5678);
        check("step17_done", 65'(da), 65'd0);
        check("step17_cnt", 65'(ca), 65'd16);

        cyc(0, 1, 0, rand65(), '0);
        repeat (5) cyc(0, 0, 1, '0, $urandom());
        cyc(0, 1, 1, 65'h3, 32'hDEAD_BEEF);
        check("reload_reg", ra, 65'h3);
        check("reload_cnt", 65'(ca), 65'd0);
        check("reload_busy", 65'(ba), 65'd1);

        cyc(0, 1, 0, rand65(), '0);
        repeat (7) cyc(0, 0, 1, '0, $urandom());
        check("pre_arst_cnt", 65'(ca), 65'd7);
        #2 rst_n = 1'b0;
        #1 mreset();
        compare();
        check("arst_reg", ra, 65'd0);
        #1 rst_n = 1'b1;

        cyc(0, 1, 0, rand65(), '0);
        repeat (7) cyc(0, 0, 1, '0, $urandom());
        cyc(1, 0, 1, rand65(), $urandom());
        check("clr_busy", 65'(ba), 65'd0);

        cyc(0, 1, 0, 65'h1_0000_0000_0000_0000, '0);
        cyc(0, 0, 1, '0, 32'h8000_0000);
        check("r2_step_reg", rb, 65'h1_8000_0000_0000_0000);
        repeat (30) cyc(0, 0, 1, '0, $urandom());
        check("r2_pre_done", 65'(db), 65'd0);
        cyc(0, 0, 1, '0, $urandom());
        check("r2_done", 65'(db), 65'd1);
        check("r2_cnt", 65'(cb), 65'd32);

        repeat (500) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 2, r >= 2 && r < 6, $urandom_range(0, 3) != 0, rand65(), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
